wb_arb: RTL

- Parametrised writeback/retire arbiter between NSRC execution pipes and an NWP-port register file.
- Sits between the pipe writeback registers (integer pipes, load-store pipe, future MUL/DIV/FP pipes) and the register file write ports.
- Grants up to NWP writebacks per cycle using rotating round-robin priority, with a same-cycle same-destination conflict guard.
- Accepts retire-without-writeback at once and keeps a 64-bit retired-instruction counter.

---
 rtl/wb_arb.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_arb.sv
// Purpose : writeback/retire arbiter, NSRC pipes onto NWP register-file write ports, rotating priority, same-dst guard.
// Latency : combinational grant/ready/write-port outputs; rr_ptr and ret_cnt update on the rising edge.
// Backpress: a writer that loses arbitration sees src_ready=0 and holds; retire-only requests are always accepted.
// Optional : define WB_ARB_STARVE_EN to enable per-source wait counters that force a starving source to the search start.
module wb_arb #(
   parameter int NSRC         = 2,
   parameter int NWP          = 1,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NSRC-1:0]     src_valid,
   input  logic [NSRC-1:0]     src_wb_en,
   input  logic [5*NSRC-1:0]   src_dst,
   input  logic [64*NSRC-1:0]  src_result,
   input  logic [64*NSRC-1:0]  src_pc,
   output logic [NSRC-1:0]     src_ready,
   output logic [NWP-1:0]      rf_wen,
   output logic [5*NWP-1:0]    rf_wdst,
   output logic [64*NWP-1:0]   rf_wdata,
   output logic [63:0]         ret_cnt,
   output logic [3:0]          ret_num
);

   localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [NSRC-1:0] wreq;
   logic [NSRC-1:0] rreq;
   logic [NSRC-1:0] grant;
   logic [PW-1:0]   start;
   logic [PW-1:0]   last_idx;
   logic            any_grant;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [63:0]     ret_cnt_q, ret_cnt_d;

   // The PC is carried for trace tooling only and never affects arbitration.
   logic unused_pc;
   assign unused_pc = ^src_pc;

   // Split each source into a real register write or a retire-only request (x0 writes retire without writing).
   always_comb begin
      wreq = '0;
      rreq = '0;
      for (int i = 0; i < NSRC; i++) begin
         wreq[i] = src_valid[i] & src_wb_en[i] & (|src_dst[5*i +: 5]);
         rreq[i] = src_valid[i] & ~(src_wb_en[i] & (|src_dst[5*i +: 5]));
      end
   end

`ifdef WB_ARB_STARVE_EN
   localparam int WW = (STARVE_LIMIT < 16) ? 4 : $clog2(STARVE_LIMIT + 1);

   logic [WW-1:0] wait_q [NSRC];
   logic [WW-1:0] wait_d [NSRC];

   // A source whose counter sits at the limit takes over the search start; lowest index wins ties.
   always_comb begin
      start = rr_ptr_q;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (wait_q[i] == WW'(STARVE_LIMIT)) start = PW'(i);
      end
   end

   // Count cycles a writer is refused; clear on grant or when idle, saturate at the limit.
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         wait_d[i] = '0;
         if (wreq[i] && !grant[i]) begin
            if (wait_q[i] == WW'(STARVE_LIMIT)) wait_d[i] = wait_q[i];
            else                                 wait_d[i] = wait_q[i] + 1'b1;
         end
      end
   end

   // Wait counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NSRC; i++) wait_q[i] <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (STARVE_LIMIT > 0);

   // Pure round-robin: the search always begins at the rotating pointer.
   always_comb begin
      start = rr_ptr_q;
   end
`endif

   // Walk writers from the start point, granting up to NWP with distinct destinations; k-th grant drives port k.
   always_comb begin
      int  ngrant;
      int  idx;
      logic conflict;
      ngrant    = 0;
      idx       = 0;
      conflict  = 1'b0;
      grant     = '0;
      rf_wen    = '0;
      rf_wdst   = '0;
      rf_wdata  = '0;
      last_idx  = rr_ptr_q;
      any_grant = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         idx = (int'(start) + k) % NSRC;
         if (rst && wreq[idx] && (ngrant < NWP)) begin
            conflict = 1'b0;
            for (int p = 0; p < NWP; p++) begin
               if ((p < ngrant) && (rf_wdst[5*p +: 5] == src_dst[5*idx +: 5])) conflict = 1'b1;
            end
            if (!conflict) begin
               grant[idx]                  = 1'b1;
               rf_wen[ngrant]              = 1'b1;
               rf_wdst[5*ngrant +: 5]      = src_dst[5*idx +: 5];
               rf_wdata[64*ngrant +: 64]   = src_result[64*idx +: 64];
               ngrant                      = ngrant + 1;
               last_idx                    = PW'(idx);
               any_grant                   = 1'b1;
            end
         end
      end
   end

   // Accept idle, retire-only and granted sources; count this cycle's retirements and advance the pointer.
   always_comb begin
      src_ready = ~src_valid | rreq | grant;
      ret_num   = '0;
      for (int i = 0; i < NSRC; i++) begin
         ret_num = ret_num + 4'(src_valid[i] & src_ready[i]);
      end
      ret_cnt_d = ret_cnt_q + 64'(ret_num);
      rr_ptr_d  = any_grant ? PW'((int'(last_idx) + 1) % NSRC) : rr_ptr_q;
   end

   // Pointer and retired-instruction counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q  <= '0;
         ret_cnt_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         ret_cnt_q <= ret_cnt_d;
      end
   end

   assign ret_cnt = ret_cnt_q;

endmodule
